sfp_frame_handler: RTL and testbench
====================================

SFP_FRAME_HANDLER -- requirements
Module: sfp_frame_handler

Interface
REQ-001 SHALL have parameter C_DATA_FRAME_BIT, default 16, width of one frame in bits.
REQ-002 SHALL have parameter C_FRAME_NUM, default 4 (range 2..16), number of frames per SFP stream word.
REQ-003 SHALL have parameter C_END_CODE, default 16'h00FF, frame value that terminates master unload.
REQ-004 SHALL have parameter C_TIMEOUT_CYC, default 1000, master wait limit in clocks.
REQ-005 i_clk  in  1  clock; one clock; all logic on rising edge.
REQ-006 i_rst  in  1  reset; asynchronous, active-high.
REQ-007 i_sfp_m_en  in  1  1 = master mode, 0 = slave mode; sampled only in IDLE.
REQ-008 i_tx_data  in  C_FRAME_NUM*C_DATA_FRAME_BIT  payload to send.
REQ-009 o_tx_stream_data  out  C_FRAME_NUM*C_DATA_FRAME_BIT  registered stream to SFP core.
REQ-010 o_sfp_start_flag  out  1  one-cycle transmit request to SFP core.
REQ-011 i_rx_stream_data  in  C_FRAME_NUM*C_DATA_FRAME_BIT  stream from SFP core.
REQ-012 i_sfp_end_flag  in  1  one-cycle pulse: transfer complete, rx stream valid.
REQ-013 o_rx_frame  out  C_DATA_FRAME_BIT  current unloaded frame.
REQ-014 o_rx_frame_idx  out  $clog2(C_FRAME_NUM)  index of o_rx_frame within stream, frame 0 = most significant.
REQ-015 o_rx_valid / i_rx_ready  out/in  1  valid-ready handshake for o_rx_frame.
REQ-016 o_busy  out  1  high in every state except IDLE.
REQ-017 o_timeout  out  1  sticky master timeout flag.

Function
REQ-018 States SHALL be IDLE, M_LOAD, M_START, M_WAIT, M_CAPTURE, M_UNLOAD, S_CAPTURE, S_LOAD, S_START.
REQ-019 IDLE: i_sfp_m_en=1 -> M_LOAD; else i_sfp_end_flag=1 -> S_CAPTURE; else stay.
REQ-020 M_LOAD and S_LOAD SHALL register i_tx_data into o_tx_stream_data; next state M_START / S_START.
REQ-021 o_sfp_start_flag SHALL be high exactly in M_START and S_START, one cycle each.
REQ-022 M_START -> M_WAIT; M_WAIT counts clocks from 0, i_sfp_end_flag -> M_CAPTURE.
REQ-023 M_CAPTURE and S_CAPTURE SHALL register i_rx_stream_data into an internal rx buffer and clear frame index to 0.
REQ-024 M_CAPTURE -> M_UNLOAD; S_CAPTURE -> M_UNLOAD-equivalent unload, then S_LOAD after last frame.
REQ-025 Unload: o_rx_valid=1, o_rx_frame = buffer frame[idx]; idx advances only on o_rx_valid & i_rx_ready.
REQ-026 Unload SHALL end on the handshake of frame idx=C_FRAME_NUM-1, or of a frame equal to C_END_CODE, whichever first (the C_END_CODE frame is itself delivered).
REQ-027 Master unload end -> IDLE; slave unload end -> S_LOAD -> S_START -> IDLE.
REQ-028 o_rx_valid held with stable o_rx_frame while i_rx_ready=0; no frame dropped or duplicated.
REQ-029 i_sfp_end_flag outside M_WAIT and IDLE SHALL be ignored.
REQ-030 i_sfp_m_en changes outside IDLE SHALL not affect the current transaction.
REQ-031 Latency: i_sfp_end_flag in M_WAIT -> first o_rx_valid 2 cycles later.

Reset
REQ-032 Asserting i_rst at any time SHALL force IDLE, zero all outputs, rx buffer, index, counter, o_timeout, aborting any transaction.

Configuration
REQ-033 With macro SFP_TIMEOUT_EN defined, M_WAIT reaching C_TIMEOUT_CYC clocks without i_sfp_end_flag SHALL set o_timeout and return to IDLE; o_timeout clears on next M_START.
REQ-034 Without SFP_TIMEOUT_EN, M_WAIT waits indefinitely; o_timeout is constant 0; counter is not built.

Structure
REQ-035 State encoding localparams and default widths SHALL live in shared package sfp_pkg.
REQ-036 Unload logic SHALL be sub-module sfp_frame_unloader (buffer, index, handshake, end-code detect).

Verification
REQ-037 Master, i_tx_data=64'h1111_2222_3333_4444 -> o_tx_stream_data equal, start pulse 2 cycles after m_en; rx 64'hAAAA_BBBB_CCCC_DDDD, ready=1 -> frames AAAA,BBBB,CCCC,DDDD idx 0..3, then IDLE.
REQ-038 Master rx 64'h0001_00FF_0003_0004 -> frames 0001, 00FF delivered, then IDLE; 0003 never valid.
REQ-039 Slave: end pulse with rx 64'h5555_6666_7777_8888, ready toggling every cycle -> four frames in order, held stable while not ready, then one start pulse carrying i_tx_data.
REQ-040 SFP_TIMEOUT_EN, C_TIMEOUT_CYC=1000, no end pulse -> o_timeout=1 and IDLE after 1000 M_WAIT cycles; next transaction clears it.
REQ-041 i_rst pulse during M_UNLOAD idx=2 -> all outputs 0, IDLE next cycle; subsequent master transaction completes normally.

Source files
------------

// File: rtl/sfp_pkg.sv
// Shared state encoding and default widths for the SFP frame handler slice.
package sfp_pkg;

  localparam int          C_DATA_FRAME_BIT_DEF = 16;
  localparam int          C_FRAME_NUM_DEF      = 4;
  localparam logic [15:0] C_END_CODE_DEF       = 16'h00FF;
  localparam int          C_TIMEOUT_CYC_DEF    = 1000;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    M_LOAD    = 4'd1,
    M_START   = 4'd2,
    M_WAIT    = 4'd3,
    M_CAPTURE = 4'd4,
    M_UNLOAD  = 4'd5,
    S_CAPTURE = 4'd6,
    S_LOAD    = 4'd7,
    S_START   = 4'd8
  } sfp_state_t;

endpackage

// File: rtl/sfp_frame_handler_if.sv
// SFP core stream signals plus the rx frame valid/ready handshake.
// master = frame handler side, slave = SFP core / frame consumer side.
interface sfp_frame_handler_if
  import sfp_pkg::*;
#(
  parameter int C_DATA_FRAME_BIT = C_DATA_FRAME_BIT_DEF,
  parameter int C_FRAME_NUM      = C_FRAME_NUM_DEF
);

  localparam int STREAM_W = C_DATA_FRAME_BIT * C_FRAME_NUM;
  localparam int IDX_W    = $clog2(C_FRAME_NUM);

  logic [STREAM_W-1:0]         o_tx_stream_data;
  logic                        o_sfp_start_flag;
  logic [STREAM_W-1:0]         i_rx_stream_data;
  logic                        i_sfp_end_flag;
  logic [C_DATA_FRAME_BIT-1:0] o_rx_frame;
  logic [IDX_W-1:0]            o_rx_frame_idx;
  logic                        o_rx_valid;
  logic                        i_rx_ready;

  modport master (
    output o_tx_stream_data,
    output o_sfp_start_flag,
    input  i_rx_stream_data,
    input  i_sfp_end_flag,
    output o_rx_frame,
    output o_rx_frame_idx,
    output o_rx_valid,
    input  i_rx_ready
  );

  modport slave (
    input  o_tx_stream_data,
    input  o_sfp_start_flag,
    output i_rx_stream_data,
    output i_sfp_end_flag,
    input  o_rx_frame,
    input  o_rx_frame_idx,
    input  o_rx_valid,
    output i_rx_ready
  );

endinterface

// File: rtl/sfp_frame_unloader.sv
// Rx buffer and frame-by-frame unload over valid/ready; frame 0 is the most
// significant slice of the captured stream. Unload ends on the last frame or end code.
module sfp_frame_unloader
  import sfp_pkg::*;
#(
  parameter int                          C_DATA_FRAME_BIT = C_DATA_FRAME_BIT_DEF,
  parameter int                          C_FRAME_NUM      = C_FRAME_NUM_DEF,
  parameter logic [C_DATA_FRAME_BIT-1:0] C_END_CODE       = C_DATA_FRAME_BIT'(C_END_CODE_DEF)
) (
  input  logic                                    i_clk,
  input  logic                                    i_rst,
  input  logic                                    i_capture,
  input  logic [C_FRAME_NUM*C_DATA_FRAME_BIT-1:0] i_rx_stream_data,
  input  logic                                    i_unload_en,
  input  logic                                    i_rx_ready,
  output logic [C_DATA_FRAME_BIT-1:0]             o_rx_frame,
  output logic [$clog2(C_FRAME_NUM)-1:0]          o_rx_frame_idx,
  output logic                                    o_rx_valid,
  output logic                                    o_done
);

  localparam int W     = C_DATA_FRAME_BIT;
  localparam int IDX_W = $clog2(C_FRAME_NUM);

  logic [W-1:0]     buf_q [C_FRAME_NUM];
  logic [IDX_W-1:0] idx_q;
  logic             xfer;
  logic             last_frame;
  logic             end_code_hit;

  assign o_rx_valid     = i_unload_en;
  assign o_rx_frame     = buf_q[idx_q];
  assign o_rx_frame_idx = idx_q;

  assign xfer         = o_rx_valid & i_rx_ready;
  assign last_frame   = (idx_q == IDX_W'(C_FRAME_NUM - 1));
  assign end_code_hit = (o_rx_frame == C_END_CODE);
  assign o_done       = xfer & (last_frame | end_code_hit);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < C_FRAME_NUM; i++) buf_q[i] <= '0;
      idx_q <= '0;
    end else if (i_capture) begin
      for (int i = 0; i < C_FRAME_NUM; i++)
        buf_q[i] <= i_rx_stream_data[(C_FRAME_NUM-1-i)*W +: W];
      idx_q <= '0;
    end else if (xfer) begin
      // Park the index at 0 once the unload completes so the next capture starts clean.
      idx_q <= o_done ? '0 : idx_q + IDX_W'(1);
    end
  end

endmodule

// File: rtl/sfp_frame_handler.sv
// SFP frame handler: master (load/start/wait/capture/unload) and slave
// (capture/unload/load/start) sequencing. Optional master wait timeout: SFP_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | sample i_sfp_m_en / i_sfp_end_flag
// M_LOAD    | master: register i_tx_data into tx stream
// M_START   | master: one-cycle start pulse to SFP core
// M_WAIT    | master: wait for end flag (optionally bounded)
// M_CAPTURE | master: capture rx stream into buffer
// M_UNLOAD  | unload frames over valid/ready (master and slave)
// S_CAPTURE | slave: capture rx stream into buffer
// S_LOAD    | slave: register i_tx_data into tx stream
// S_START   | slave: one-cycle start pulse to SFP core
module sfp_frame_handler
  import sfp_pkg::*;
#(
  parameter int                          C_DATA_FRAME_BIT = C_DATA_FRAME_BIT_DEF,
  parameter int                          C_FRAME_NUM      = C_FRAME_NUM_DEF,
  parameter logic [C_DATA_FRAME_BIT-1:0] C_END_CODE       = C_DATA_FRAME_BIT'(C_END_CODE_DEF),
  parameter int                          C_TIMEOUT_CYC    = C_TIMEOUT_CYC_DEF
) (
  input  logic                                    i_clk,
  input  logic                                    i_rst,
  input  logic                                    i_sfp_m_en,
  input  logic [C_FRAME_NUM*C_DATA_FRAME_BIT-1:0] i_tx_data,
  sfp_frame_handler_if.master                     bus,
  output logic                                    o_busy,
  output logic                                    o_timeout
);

  localparam int STREAM_W = C_FRAME_NUM * C_DATA_FRAME_BIT;
  localparam int IDX_W    = $clog2(C_FRAME_NUM);

  if (C_FRAME_NUM < 2 || C_FRAME_NUM > 16 || C_TIMEOUT_CYC < 1) begin : g_bad_param
    $error("sfp_frame_handler: C_FRAME_NUM must be 2..16 and C_TIMEOUT_CYC >= 1");
  end

  sfp_state_t              state_q, state_d;
  logic                    slave_q;
  logic [STREAM_W-1:0]     tx_stream_q;
  logic                    capture;
  logic                    unload_done;
  logic                    timeout_reach;
  logic [C_DATA_FRAME_BIT-1:0] rx_frame;
  logic [IDX_W-1:0]        rx_frame_idx;
  logic                    rx_valid;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (i_sfp_m_en)              state_d = M_LOAD;
        else if (bus.i_sfp_end_flag) state_d = S_CAPTURE;
      end
      M_LOAD:    state_d = M_START;
      M_START:   state_d = M_WAIT;
      M_WAIT: begin
        if (bus.i_sfp_end_flag) state_d = M_CAPTURE;
        else if (timeout_reach) state_d = IDLE;
      end
      M_CAPTURE: state_d = M_UNLOAD;
      S_CAPTURE: state_d = M_UNLOAD;
      M_UNLOAD: begin
        if (unload_done) state_d = slave_q ? S_LOAD : IDLE;
      end
      S_LOAD:    state_d = S_START;
      S_START:   state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // The unload state is shared; this flag remembers which side owns the transaction.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      slave_q     <= 1'b0;
      tx_stream_q <= '0;
    end else begin
      if (state_q == S_CAPTURE)   slave_q <= 1'b1;
      else if (state_q == M_LOAD) slave_q <= 1'b0;
      if (state_q == M_LOAD || state_q == S_LOAD) tx_stream_q <= i_tx_data;
    end
  end

`ifdef SFP_TIMEOUT_EN
  localparam int CNT_W = $clog2(C_TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] wait_cnt_q;
  logic             timeout_q;

  assign timeout_reach = (wait_cnt_q == CNT_W'(C_TIMEOUT_CYC - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      if (state_q == M_WAIT) wait_cnt_q <= wait_cnt_q + CNT_W'(1);
      else                   wait_cnt_q <= '0;
      // Cleared while loading so the flag is already low during the next start pulse.
      if (state_q == M_WAIT && !bus.i_sfp_end_flag && timeout_reach) timeout_q <= 1'b1;
      else if (state_q == M_LOAD)                                   timeout_q <= 1'b0;
    end
  end

  assign o_timeout = timeout_q;
`else
  assign timeout_reach = 1'b0;
  assign o_timeout     = 1'b0;
`endif

  assign capture = (state_q == M_CAPTURE) || (state_q == S_CAPTURE);

  sfp_frame_unloader #(
    .C_DATA_FRAME_BIT (C_DATA_FRAME_BIT),
    .C_FRAME_NUM      (C_FRAME_NUM),
    .C_END_CODE       (C_END_CODE)
  ) u_unloader (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_capture        (capture),
    .i_rx_stream_data (bus.i_rx_stream_data),
    .i_unload_en      (state_q == M_UNLOAD),
    .i_rx_ready       (bus.i_rx_ready),
    .o_rx_frame       (rx_frame),
    .o_rx_frame_idx   (rx_frame_idx),
    .o_rx_valid       (rx_valid),
    .o_done           (unload_done)
  );

  assign bus.o_rx_frame       = rx_frame;
  assign bus.o_rx_frame_idx   = rx_frame_idx;
  assign bus.o_rx_valid       = rx_valid;
  assign bus.o_tx_stream_data = tx_stream_q;
  assign bus.o_sfp_start_flag = (state_q == M_START) || (state_q == S_START);
  assign o_busy               = (state_q != IDLE);

endmodule

// File: tb/tb_sfp_frame_handler.sv
// Bench for sfp_frame_handler: scoreboard of expected rx frames and tx start
// payloads, popped by a negedge monitor on each handshake / start pulse.
module tb_sfp_frame_handler;
  import sfp_pkg::*;

  localparam int W  = 16;
  localparam int FN = 4;
  localparam int TO = 1000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m_en = 1'b0;
  logic [63:0]   tx_data = '0;
  logic          busy;
  logic          timeout;
  logic          toggle_en = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];
  logic [63:0] tx_q[$];

  sfp_frame_handler_if #(.C_DATA_FRAME_BIT(W), .C_FRAME_NUM(FN)) bus ();

  sfp_frame_handler #(
    .C_DATA_FRAME_BIT (W),
    .C_FRAME_NUM      (FN),
    .C_END_CODE       (16'h00FF),
    .C_TIMEOUT_CYC    (TO)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_sfp_m_en (m_en),
    .i_tx_data  (tx_data),
    .bus        (bus),
    .o_busy     (busy),
    .o_timeout  (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void push_frames(input logic [63:0] s);
    logic [15:0] f;
    for (int i = 0; i < FN; i++) begin
      f = s[(FN-1-i)*W +: W];
      exp_q.push_back({16'(i), f});
      if (f == 16'h00FF) break;
    end
  endfunction

  // Monitor: handshakes, start pulses and hold stability.
  initial begin
    logic        held_v;
    logic [15:0] held_f;
    logic [1:0]  held_i;
    logic [31:0] e;
    logic [63:0] t;
    held_v = 1'b0;
    held_f = '0;
    held_i = '0;
    forever begin
      @(negedge clk);
      if (held_v && !rst) begin
        chk("hold_valid", bus.o_rx_valid, 1);
        chk("hold_frame", bus.o_rx_frame, held_f);
        chk("hold_idx", bus.o_rx_frame_idx, held_i);
      end
      held_v = bus.o_rx_valid && !bus.i_rx_ready && !rst;
      held_f = bus.o_rx_frame;
      held_i = bus.o_rx_frame_idx;
      if (bus.o_rx_valid && bus.i_rx_ready) begin
        chk("rx_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("rx_frame", bus.o_rx_frame, e[15:0]);
          chk("rx_idx", bus.o_rx_frame_idx, e[31:16]);
        end
      end
      if (bus.o_sfp_start_flag) begin
        chk("tx_pending", tx_q.size() != 0, 1);
        if (tx_q.size() != 0) begin
          t = tx_q.pop_front();
          chk("tx_stream", bus.o_tx_stream_data, t);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (toggle_en) bus.i_rx_ready = ~bus.i_rx_ready;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_idle(input int max);
    for (int i = 0; i < max && busy; i++) begin
      @(posedge clk);
      #1;
    end
    chk("idle", busy, 0);
    chk("rx_drained", exp_q.size(), 0);
    chk("tx_drained", tx_q.size(), 0);
  endtask

  // Drives a master transaction up to the first valid frame.
  task automatic master_begin(input logic [63:0] txd, input logic [63:0] rxd, input int wait_cyc);
    tx_data = txd;
    tx_q.push_back(txd);
    m_en = 1'b1;
    @(posedge clk); #1;
    m_en = 1'b0;
    chk("m_load_nostart", bus.o_sfp_start_flag, 0);
    chk("m_load_busy", busy, 1);
    @(posedge clk); #1;
    chk("m_start", bus.o_sfp_start_flag, 1);
    chk("m_start_timeout", timeout, 0);
    repeat (wait_cyc) @(posedge clk);
    #1;
    chk("m_wait_busy", busy, 1);
    chk("m_wait_novalid", bus.o_rx_valid, 0);
    bus.i_rx_stream_data = rxd;
    push_frames(rxd);
    bus.i_sfp_end_flag = 1'b1;
    @(posedge clk); #1;
    bus.i_sfp_end_flag = 1'b0;
    chk("lat_capture", bus.o_rx_valid, 0);
    @(posedge clk); #1;
    chk("lat_valid", bus.o_rx_valid, 1);
  endtask

  initial begin
    bus.i_rx_stream_data = '0;
    bus.i_sfp_end_flag   = 1'b0;
    bus.i_rx_ready       = 1'b1;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_start", bus.o_sfp_start_flag, 0);
    chk("rst_valid", bus.o_rx_valid, 0);
    chk("rst_tx", bus.o_tx_stream_data, 0);
    chk("rst_frame", bus.o_rx_frame, 0);
    chk("rst_idx", bus.o_rx_frame_idx, 0);
    chk("rst_timeout", timeout, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Master full unload, always ready.
    master_begin(64'h1111_2222_3333_4444, 64'hAAAA_BBBB_CCCC_DDDD, 3);
    wait_idle(40);

    // Master unload terminated by end code.
    master_begin(64'h0F0F_F0F0_0F0F_F0F0, 64'h0001_00FF_0003_0004, 2);
    wait_idle(40);
    chk("endcode_novalid", bus.o_rx_valid, 0);

`ifdef SFP_TIMEOUT_EN
    // Master wait expires with no end flag.
    tx_data = 64'hABCD_0000_1234_0000;
    tx_q.push_back(tx_data);
    m_en = 1'b1;
    @(posedge clk); #1;
    m_en = 1'b0;
    @(posedge clk); #1;
    chk("to_start", bus.o_sfp_start_flag, 1);
    repeat (TO) @(posedge clk);
    #1;
    chk("to_last_wait_busy", busy, 1);
    chk("to_not_yet", timeout, 0);
    @(posedge clk); #1;
    chk("to_idle", busy, 0);
    chk("to_flag", timeout, 1);
    master_begin(64'h0123_4567_89AB_CDEF, 64'h1000_2000_3000_4000, 1);
    wait_idle(40);
    chk("to_cleared", timeout, 0);
`else
    // Without the timeout option the master waits indefinitely.
    master_begin(64'h0123_4567_89AB_CDEF, 64'h1000_2000_3000_4000, TO + 100);
    wait_idle(40);
    chk("no_timeout", timeout, 0);
`endif

    // Slave: end flag in IDLE, ready toggling, stray end flag and m_en ignored.
    tx_data = 64'h9999_AAAA_BBBB_CCCC;
    tx_q.push_back(tx_data);
    bus.i_rx_stream_data = 64'h5555_6666_7777_8888;
    push_frames(64'h5555_6666_7777_8888);
    bus.i_rx_ready = 1'b0;
    toggle_en = 1'b1;
    bus.i_sfp_end_flag = 1'b1;
    @(posedge clk); #1;
    bus.i_sfp_end_flag = 1'b0;
    chk("s_capture_busy", busy, 1);
    @(posedge clk); #1;
    chk("s_valid", bus.o_rx_valid, 1);
    @(posedge clk); #1;
    bus.i_rx_stream_data = 64'hDEAD_BEEF_DEAD_BEEF;
    bus.i_sfp_end_flag = 1'b1;
    m_en = 1'b1;
    @(posedge clk); #1;
    bus.i_sfp_end_flag = 1'b0;
    m_en = 1'b0;
    wait_idle(60);
    toggle_en = 1'b0;
    @(posedge clk); #1;
    bus.i_rx_ready = 1'b1;

    // Reset in the middle of an unload, then a clean transaction.
    master_begin(64'h7777_8888_9999_AAAA, 64'h1234_5678_9ABC_DEF0, 2);
    for (int i = 0; i < 20 && !(bus.o_rx_valid && bus.o_rx_frame_idx == 2); i++) begin
      @(posedge clk); #1;
    end
    chk("mid_idx", bus.o_rx_frame_idx, 2);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", bus.o_rx_valid, 0);
    chk("mid_rst_tx", bus.o_tx_stream_data, 0);
    chk("mid_rst_frame", bus.o_rx_frame, 0);
    chk("mid_rst_idx", bus.o_rx_frame_idx, 0);
    chk("mid_rst_start", bus.o_sfp_start_flag, 0);
    chk("mid_rst_pending", exp_q.size(), 2);
    exp_q.delete();
    @(posedge clk); #1;
    chk("mid_rst_idle", busy, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    master_begin(64'h0BAD_CAFE_0BAD_CAFE, 64'hFEDC_BA98_7654_3210, 2);
    wait_idle(40);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
